// File: rtl/conf_regs_loader_if.sv
// Host receive side (FT245 RX) byte handshake into the configuration loader.
// rx_rdy/rx_data are held by the host until the loader pulses rx_ack.
interface conf_regs_loader_if;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       rx_ack;

    modport master (output rx_data, output rx_rdy, input rx_ack);
    modport slave  (input rx_data, input rx_rdy, output rx_ack);
endinterface

// File: rtl/conf_regs_loader.sv
// Configuration register bank loader.
// Assembles 3-byte frames (address, data high, data low) from the host
// byte stream and writes them into a flat register bank. Address 0 is a
// self-clearing request register. A partial frame that stalls for
// TIMEOUT_CYCLES edges is dropped and flagged.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | waiting for the address byte
// S_GOTADR | address held, waiting for data high byte
// S_GOTDH  | data high held, waiting for data low byte
// S_WRITE  | one-cycle commit of the assembled frame
module conf_regs_loader #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_REGS       = 11,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                           clk,
    input  logic                           rst,
    conf_regs_loader_if.slave              rx,
    output logic [DATA_WIDTH*NUM_REGS-1:0] registers,
    output logic                           wr_strobe,
    output logic [7:0]                     wr_addr,
    output logic                           frame_err
);

    localparam int         CW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GOTADR = 2'd1,
        S_GOTDH  = 2'd2,
        S_WRITE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7:0]            addr_q, data_h_q, data_l_q;
    logic                  rx_ack_q;
    logic                  capture;
    logic                  do_write;
    logic                  bad_addr;
    logic                  timeout;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    assign rx.rx_ack = rx_ack_q;

    // Next-state, timeout counter and commit decisions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        capture  = rx.rx_rdy && !rx_ack_q && (state_q != S_WRITE);
        do_write = 1'b0;
        bad_addr = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (capture) state_d = S_GOTADR;
            end
            S_GOTADR, S_GOTDH: begin
                // A byte arriving on the expiry edge takes priority over the timeout.
                if (capture) begin
                    state_d = (state_q == S_GOTADR) ? S_GOTDH : S_WRITE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                if (addr_q < NUM_REGS_B) do_write = 1'b1;
                else                     bad_addr = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, frame bytes, handshake and status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_h_q  <= '0;
            data_l_q  <= '0;
            rx_ack_q  <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rx_ack_q  <= capture;
            wr_strobe <= do_write;
            frame_err <= timeout | bad_addr;
            if (do_write) wr_addr <= addr_q;
            if (capture) begin
                case (state_q)
                    S_IDLE:   addr_q   <= rx.rx_data;
                    S_GOTADR: data_h_q <= rx.rx_data;
                    S_GOTDH:  data_l_q <= rx.rx_data;
                    default:  ;
                endcase
            end
        end
    end

    // Register bank; register 0 self-clears one cycle after any write to it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int h = 0; h < NUM_REGS; h++) regs[h] <= '0;
        end else begin
            for (int h = 0; h < NUM_REGS; h++) begin
                if (do_write && (addr_q == 8'(h))) regs[h] <= {data_h_q, data_l_q};
                else if (h == 0)                   regs[h] <= '0;
            end
        end
    end

    // Flatten the bank for the configuration wrapper.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign registers[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

endmodule

// File: doc/conf_regs_loader.md
# conf_regs_loader

Byte-stream loader for the configuration register bank. It consumes bytes from the host receive interface (FT245 RX side), assembles 3-byte write frames (address, data high, data low), and stores them in `NUM_REGS` registers of `DATA_WIDTH` bits. The bank is exported as one flat bit array, which the configuration wrapper splits into named fields. Address 0 is the self-clearing request register.

## Interface
Parameters:
- `DATA_WIDTH`, 16, register width in bits; must be 16 because the frame carries 2 data bytes
- `NUM_REGS`, 11, number of registers (addresses 0..NUM_REGS-1)
- `TIMEOUT_CYCLES`, 1000, maximum idle cycles between bytes of one frame

Ports:
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  synchronous, active-low reset
- `rx_data`  in  8  received byte
- `rx_rdy`  in  1  `rx_data` valid; held until acknowledged
- `rx_ack`  out  1  one-cycle pulse; byte consumed
- `registers`  out  DATA_WIDTH*NUM_REGS  flat bank; register h occupies bits [(h+1)*DATA_WIDTH-1 : h*DATA_WIDTH]
- `wr_strobe`  out  1  one-cycle pulse in the cycle a register takes its new value
- `wr_addr`  out  8  address of the last completed valid write
- `frame_err`  out  1  one-cycle pulse on timeout or out-of-range address

## Operation
- Reset (`rst`=0 at a clock edge):
  - all registers 0; `rx_ack`, `wr_strobe`, `frame_err` 0; `wr_addr` 0
  - FSM goes to IDLE; timeout counter cleared
  - a partial frame is discarded
- Byte capture:
  - a byte is captured on an edge where `rx_rdy`=1 and `rx_ack`=0
  - `rx_ack`=1 for the following cycle
  - the source must change or deassert `rx_rdy`/`rx_data` in the cycle after `rx_ack`
  - maximum rate: one byte per 2 cycles
- FSM states:
  - IDLE: capture stores `addr`, go to GOT_ADDR
  - GOT_ADDR: capture stores `data_h`, go to GOT_DH
  - GOT_DH: capture stores `data_l`, go to WRITE
  - WRITE: lasts one cycle, then IDLE; no capture occurs in WRITE
- WRITE with `addr` < NUM_REGS:
  - `registers[addr]` = {data_h, data_l}
  - `wr_strobe`=1, `wr_addr`=addr
- WRITE with `addr` >= NUM_REGS:
  - no register changes
  - `frame_err`=1, `wr_strobe` stays 0, `wr_addr` unchanged
- Timeout:
  - in GOT_ADDR or GOT_DH, the counter increments on every edge without a capture and clears on each capture
  - when the counter reaches TIMEOUT_CYCLES, the FSM goes to IDLE, `frame_err` pulses once, and the partial frame is dropped
  - the counter is held at 0 in IDLE and WRITE
  - a capture in the same cycle the count would reach the limit wins: the byte is accepted and the counter clears
- Request register (address 0):
  - after a write, it holds the written value for exactly one cycle, then clears to 0 on the next edge
  - a write to address 0 in consecutive frames produces separate one-cycle pulses
- All other registers hold their value until rewritten or reset.
- `rx_rdy` held high during WRITE is captured in the next IDLE cycle; no byte is lost.

## Timing
- Edge N: `data_l` captured.
- Edge N+1: register bank updated, `wr_strobe`/`frame_err` asserted; the new value is visible from N+1.
- Edge N+2: `wr_strobe` deasserts; register 0 clears if it was the target.
- End-to-end, first byte captured to register valid: at least 6 edges.
- All outputs are registered; there are no combinational paths from the inputs.

## Test plan
- Reset, then frame 0x07,0x12,0x34 → `registers[7]`=0x1234 one edge after the third capture; `wr_strobe` 1 cycle, `wr_addr`=7, `rx_ack` pulsed 3 times.
- Frame 0x00,0x00,0x01 → register 0 reads 0x0001 for exactly 1 cycle, then 0; a back-to-back second identical frame gives a second pulse.
- Frame 0x0B,0xFF,0xFF with NUM_REGS=11 → no register changes, `frame_err` 1 cycle, `wr_strobe` 0.
- Bytes 0x03,0xAA, then a gap of TIMEOUT_CYCLES → `frame_err` pulse, FSM in IDLE; a following frame 0x03,0x00,0x55 gives `registers[3]`=0x0055, not 0xAA00/0xAA55.
- A third byte arriving on the exact cycle the timeout would expire → frame accepted, no `frame_err`.
- `rst`=0 after 2 bytes of a frame → all registers 0; a fresh frame 0x09,0x00,0x02 then writes `registers[9]`=0x0002 correctly.
